eth_rx_frame_filter: RTL

Sits directly downstream of the SFP+ 10G Ethernet AXI4-Stream RX output, in the same clock domain. It parses the Ethernet MAC header of each frame, which arrives without preamble or FCS. Frames are passed unmodified when they match the configured destination MAC / broadcast / EtherType rules; otherwise they are dropped whole. It keeps saturating accept/drop counters for status readout.

---
 rtl/eth_pkg.sv | 22 ++
 rtl/sat_counter.sv | 23 ++
 rtl/eth_rx_frame_filter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared Ethernet header constants and filter state type
package eth_pkg;

    localparam logic [47:0] ETH_BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;
    localparam logic [15:0] ETHERTYPE_IPV4    = 16'h0800;
    localparam logic [15:0] ETHERTYPE_ARP     = 16'h0806;

    // Byte offsets within the frame; EtherType lives in word 1.
    localparam int DST_MAC_OFS   = 0;
    localparam int ETHERTYPE_OFS = 12;
    localparam int ETHERTYPE_LANE = ETHERTYPE_OFS - 8;
    localparam int RUNT_KEEP_BIT  = ETHERTYPE_LANE + 1;

    typedef enum logic [2:0] {
        HDR0,
        HDR1,
        PASS,
        FLUSH,
        DROP
    } filt_state_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - increment-only counter that holds at all-ones
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/eth_rx_frame_filter.sv
// rtl/eth_rx_frame_filter.sv - drops whole frames failing MAC/EtherType rules
module eth_rx_frame_filter
    import eth_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic [63:0]          s_axis_tdata,
    input  logic                 s_axis_tlast,
    input  logic [7:0]           s_axis_tkeep,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [63:0]          m_axis_tdata,
    output logic                 m_axis_tlast,
    output logic [7:0]           m_axis_tkeep,
    input  logic [47:0]          cfg_local_mac,
    input  logic                 cfg_accept_broadcast,
    input  logic                 cfg_promiscuous,
    input  logic                 cfg_ethertype_en,
    input  logic [15:0]          cfg_ethertype,
    output logic [CNT_WIDTH-1:0] cnt_accepted,
    output logic [CNT_WIDTH-1:0] cnt_dropped
);

    filt_state_e state_q, state_d;
    logic [63:0] h_data_q, h_data_d;
    logic [7:0]  h_keep_q, h_keep_d;
    logic        o_valid_q, o_valid_d;
    logic [63:0] o_data_q, o_data_d;
    logic [7:0]  o_keep_q, o_keep_d;
    logic        o_last_q, o_last_d;
    logic        inc_acc, inc_drop;
    logic        out_free, s_fire, runt1, match;
    logic [47:0] dst_mac;
    logic [15:0] ethertype;

    assign out_free = !o_valid_q || m_axis_tready;
    assign s_fire   = s_axis_tvalid && s_axis_tready;
    assign runt1    = s_axis_tlast && !s_axis_tkeep[RUNT_KEEP_BIT];
    assign ethertype = {s_axis_tdata[8*ETHERTYPE_LANE +: 8], s_axis_tdata[8*(ETHERTYPE_LANE+1) +: 8]};

    // Word 0 is parked in H while word 1 is on the input, so the MAC comes from H.
    always_comb begin
        dst_mac = '0;
        for (int i = 0; i < 6; i++) begin
            dst_mac[47-8*i -: 8] = h_data_q[8*(DST_MAC_OFS+i) +: 8];
        end
    end

    assign match = (cfg_promiscuous || (dst_mac == cfg_local_mac) ||
                    (cfg_accept_broadcast && (dst_mac == ETH_BROADCAST_MAC))) &&
                   (!cfg_ethertype_en || (ethertype == cfg_ethertype));

    always_comb begin
        state_d       = state_q;
        h_data_d      = h_data_q;
        h_keep_d      = h_keep_q;
        o_valid_d     = out_free ? 1'b0 : o_valid_q;
        o_data_d      = o_data_q;
        o_keep_d      = o_keep_q;
        o_last_d      = o_last_q;
        inc_acc       = 1'b0;
        inc_drop      = 1'b0;
        s_axis_tready = 1'b0;
        case (state_q)
            HDR0: begin
                s_axis_tready = 1'b1;
                if (s_fire) begin
                    h_data_d = s_axis_tdata;
                    h_keep_d = s_axis_tkeep;
                    if (s_axis_tlast) inc_drop = 1'b1;
                    else              state_d  = HDR1;
                end
            end
            HDR1: begin
                s_axis_tready = out_free;
                if (s_fire) begin
                    if (match && !runt1) begin
                        o_valid_d = 1'b1;
                        o_data_d  = h_data_q;
                        o_keep_d  = h_keep_q;
                        o_last_d  = 1'b0;
                        h_data_d  = s_axis_tdata;
                        h_keep_d  = s_axis_tkeep;
                        inc_acc   = 1'b1;
                        state_d   = s_axis_tlast ? FLUSH : PASS;
                    end else begin
                        inc_drop = 1'b1;
                        state_d  = s_axis_tlast ? HDR0 : DROP;
                    end
                end
            end
            PASS: begin
                s_axis_tready = out_free;
                if (s_fire) begin
                    o_valid_d = 1'b1;
                    o_data_d  = h_data_q;
                    o_keep_d  = h_keep_q;
                    o_last_d  = 1'b0;
                    h_data_d  = s_axis_tdata;
                    h_keep_d  = s_axis_tkeep;
                    if (s_axis_tlast) state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (out_free) begin
                    o_valid_d = 1'b1;
                    o_data_d  = h_data_q;
                    o_keep_d  = h_keep_q;
                    o_last_d  = 1'b1;
                    state_d   = HDR0;
                end
            end
            DROP: begin
                s_axis_tready = 1'b1;
                if (s_fire && s_axis_tlast) state_d = HDR0;
            end
            default: state_d = HDR0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= HDR0;
            h_data_q  <= '0;
            h_keep_q  <= '0;
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_keep_q  <= '0;
            o_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            h_data_q  <= h_data_d;
            h_keep_q  <= h_keep_d;
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            o_keep_q  <= o_keep_d;
            o_last_q  <= o_last_d;
        end
    end

    assign m_axis_tvalid = o_valid_q;
    assign m_axis_tdata  = o_data_q;
    assign m_axis_tkeep  = o_keep_q;
    assign m_axis_tlast  = o_last_q;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_acc (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (inc_acc),
        .count_o (cnt_accepted)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_drop (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (inc_drop),
        .count_o (cnt_dropped)
    );

endmodule
